pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Runs on the PLL output clock. Qualifies the PLL lock signal and sequences
//  per-domain reset release. Re-asserts all resets on loss of lock and counts
//  loss events. Emits a periodic tick once the system is up.
//  Sits between the PLL wrapper and all downstream logic on the board top.
// PARAMETERS
//  NUM_DOMAINS  3     reset outputs, released in index order 0..N-1 (>=1)
//  LOCK_CYCLES  1024  consecutive cycles lock_sync must stay high before release (>=2)
//  STAGE_GAP    16    cycles between successive domain releases (>=1)
//  SYNC_STAGES  2     flops in the pll_locked synchroniser (>=2)
//  LOSS_CNT_W   8     width of lost_count
//  TICK_DIV     60    tick period in cycles (>=2); 60 = 1 us at 60 MHz
// PORTS
//  clock_in    in   1            PLL output clock; sole clock
//  reset       in   1            asynchronous, active-high
//  pll_locked  in   1            raw PLL LOCK, asynchronous to clock_in
//  lost_clear  in   1            synchronous clear of lost_count
//  rst_out     out  NUM_DOMAINS  active-high reset per domain
//  ready       out  1            all domains released, lock stable
//  tick        out  1            1-cycle strobe every TICK_DIV cycles in RUN
//  lost_count  out  LOSS_CNT_W   saturating count of lock-loss events
// BEHAVIOUR
//  - Reset values: rst_out all ones, ready 0, tick 0, lost_count 0.
//    Synchroniser flops 0, state IDLE, all counters 0.
//    reset acts immediately at any time, including mid-sequence.
//  - lock_sync is pll_locked after SYNC_STAGES flops. All decisions use lock_sync.
//  - All outputs are registered.
//  - FSM states:
//    IDLE: rst_out all ones, ready 0. lock_sync=1 -> COUNT with cnt=0.
//    COUNT: cnt increments each cycle.
//      lock_sync=0 -> IDLE, cnt=0.
//      At cnt==LOCK_CYCLES-1 with lock_sync=1 -> RELEASE, idx=0.
//    RELEASE: rst_out[0] is 0 from the first RELEASE cycle.
//      rst_out[i] falls STAGE_GAP cycles after rst_out[i-1].
//      ready rises on the same edge that rst_out[N-1] falls; enter RUN there.
//      NUM_DOMAINS=1: rst_out[0] and ready fall/rise together.
//    RUN: ready 1, rst_out all zero.
//    Loss of lock (lock_sync=0) in RELEASE or RUN:
//      next edge -> IDLE; rst_out all ones, ready 0.
//      lost_count +1, saturating at all-ones.
//  - Timing: first cycle t that lock_sync=1 in IDLE -> rst_out[0] falls at
//    edge t+LOCK_CYCLES+1, then rst_out[i] at +i*STAGE_GAP.
//  - Loss of lock in IDLE or COUNT is not counted.
//  - lost_clear=1 clears lost_count next edge.
//    lost_clear and a loss in the same cycle -> lost_count=1.
//  - tick: divider counts 0..TICK_DIV-1 only in RUN; held at 0 elsewhere.
//    tick=1 in the cycle divider==TICK_DIV-1; first tick TICK_DIV cycles after
//    ready rises. tick is forced 0 on the edge leaving RUN.
//  - Counter widths use $clog2 of the respective maxima. No wrap in COUNT or
//    RELEASE: the state exits before any wrap.
// STRUCTURE
//  - Package pll_seq_pkg holds:
//    state enum {IDLE, COUNT, RELEASE, RUN} and a width helper function (clog2, min 1).
//  - One sub-module: sync_ff (parametrised SYNC_STAGES bit synchroniser,
//    async reset to 0), instanced for pll_locked.
//  - Everything else is in this module: FSM, cycle counter, stage index,
//    tick divider and loss counter.
// TESTING  (NUM_DOMAINS=3, LOCK_CYCLES=8, STAGE_GAP=4, SYNC_STAGES=2, TICK_DIV=5, LOSS_CNT_W=2)
//  1. reset high, then low; pll_locked=0 for 50 cycles
//     -> rst_out=3'b111, ready=0, tick=0, lost_count=0 throughout.
//  2. pll_locked rises and is held high -> lock_sync high 2 cycles later (t).
//     rst_out[0] falls at t+9, [1] at t+13, [2] and ready at t+17.
//     First tick at t+22, then every 5 cycles.
//  3. Lock glitches low for 1 cycle at COUNT cnt=5 -> back to IDLE; full
//     8-cycle qualification restarts; lost_count stays 0.
//  4. Lock drops in RUN -> rst_out=3'b111 and ready=0 one edge after
//     lock_sync falls; tick stops; lost_count=1. Relock -> full sequence again.
//  5. Cause 4 losses -> lost_count saturates at 3.
//     Assert lost_clear in the same cycle as a loss -> lost_count=1.
//  6. Assert reset mid-RELEASE (after rst_out[0] fell)
//     -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pll_seq_pkg
// Brief   : Shared state encoding and width helper for the PLL lock sequencer.
// Revision: 1.0
// ============================================================================
package pll_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } pll_state_e;

    // Width needed to hold values 0..max_value-1, never less than one bit.
    function automatic int width_of(input int max_value);
        int w;
        w = $clog2(max_value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sequencer_sync_ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_ff
// Brief   : Multi-flop single-bit synchroniser, asynchronously reset to 0.
// Revision: 1.0
// ============================================================================
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_sequencer
// Brief   : Qualifies PLL lock, releases domain resets in order, counts lock
//           losses and emits a periodic tick while the system is up.
// Revision: 1.0
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 3,
    parameter int LOCK_CYCLES = 1024,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOSS_CNT_W  = 8,
    parameter int TICK_DIV    = 60
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   lost_clear,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic                   tick,
    output logic [LOSS_CNT_W-1:0]  lost_count
);

    localparam int c_CNT_MAX = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
    localparam int c_CNT_W   = width_of(c_CNT_MAX);
    localparam int c_IDX_W   = width_of(NUM_DOMAINS);
    localparam int c_DIV_W   = width_of(TICK_DIV);

    localparam logic [c_CNT_W-1:0]     c_LOCK_LAST = c_CNT_W'(LOCK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]     c_GAP_LAST  = c_CNT_W'(STAGE_GAP - 1);
    localparam logic [c_DIV_W-1:0]     c_DIV_LAST  = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_IDX_W-1:0]     c_IDX_PEN   =
        c_IDX_W'((NUM_DOMAINS >= 2) ? (NUM_DOMAINS - 2) : 0);
    localparam logic [NUM_DOMAINS-1:0] c_ALL_ONES  = '1;
    localparam logic [LOSS_CNT_W-1:0]  c_LOST_MAX  = '1;
    localparam logic [LOSS_CNT_W-1:0]  c_LOST_ONE  = LOSS_CNT_W'(1);

    logic                   w_lock_sync;
    logic                   w_loss;
    pll_state_e             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_DIV_W-1:0]     r_div;
    logic [NUM_DOMAINS-1:0] r_rst_out;
    logic                   r_ready;
    logic                   r_tick;
    logic [LOSS_CNT_W-1:0]  r_lost_count;

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clock_in),
        .rst (reset),
        .i_d (pll_locked),
        .o_q (w_lock_sync)
    );

    // Only a drop after qualification completed counts as a loss event.
    assign w_loss = ((r_state == RELEASE) || (r_state == RUN)) && !w_lock_sync;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_div     <= '0;
            r_rst_out <= c_ALL_ONES;
            r_ready   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rst_out <= c_ALL_ONES;
                    r_ready   <= 1'b0;
                    r_cnt     <= '0;
                    r_idx     <= '0;
                    r_div     <= '0;
                    if (w_lock_sync) begin
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!w_lock_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_LOCK_LAST) begin
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        // Shifting in zeros releases domains lowest index first.
                        r_rst_out <= c_ALL_ONES << 1;
                        if (NUM_DOMAINS == 1) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                            r_div   <= '0;
                        end else begin
                            r_state <= RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!w_lock_sync) begin
                        r_state   <= IDLE;
                        r_rst_out <= c_ALL_ONES;
                        r_ready   <= 1'b0;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                    end else if (r_cnt == c_GAP_LAST) begin
                        r_cnt     <= '0;
                        r_idx     <= r_idx + c_IDX_W'(1);
                        r_rst_out <= r_rst_out << 1;
                        if (r_idx == c_IDX_PEN) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                            r_div   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!w_lock_sync) begin
                        r_state   <= IDLE;
                        r_rst_out <= c_ALL_ONES;
                        r_ready   <= 1'b0;
                        r_div     <= '0;
                    end else begin
                        r_tick <= (r_div == c_DIV_LAST);
                        r_div  <= (r_div == c_DIV_LAST) ? '0 : (r_div + c_DIV_W'(1));
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rst_out <= c_ALL_ONES;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over increment, but a loss in the clearing cycle still counts.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_lost_count <= '0;
        end else if (lost_clear) begin
            r_lost_count <= w_loss ? c_LOST_ONE : '0;
        end else if (w_loss && (r_lost_count != c_LOST_MAX)) begin
            r_lost_count <= r_lost_count + c_LOST_ONE;
        end
    end

    assign rst_out    = r_rst_out;
    assign ready      = r_ready;
    assign tick       = r_tick;
    assign lost_count = r_lost_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pll_lock_sequencer
// Brief   : Self-checking bench: run-length reference model plus directed
//           lock/loss/reset scenarios with literal expectations.
// Revision: 1.0
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int N     = 3;
    localparam int LOCK  = 8;
    localparam int GAP   = 4;
    localparam int SS    = 2;
    localparam int TDIV  = 5;
    localparam int LW    = 2;
    localparam int REL_L = LOCK + 1 + (N - 1) * GAP;
    localparam int LMAX  = (1 << LW) - 1;

    logic          clock_in   = 1'b0;
    logic          reset      = 1'b1;
    logic          pll_locked = 1'b0;
    logic          lost_clear = 1'b0;
    logic [N-1:0]  rst_out;
    logic          ready;
    logic          tick;
    logic [LW-1:0] lost_count;

    int n_checks = 0;
    int n_errors = 0;

    pll_lock_sequencer #(
        .NUM_DOMAINS (N),
        .LOCK_CYCLES (LOCK),
        .STAGE_GAP   (GAP),
        .SYNC_STAGES (SS),
        .LOSS_CNT_W  (LW),
        .TICK_DIV    (TDIV)
    ) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .pll_locked (pll_locked),
        .lost_clear (lost_clear),
        .rst_out    (rst_out),
        .ready      (ready),
        .tick       (tick),
        .lost_count (lost_count)
    );

    initial forever #5 clock_in = ~clock_in;

    // Reference model: everything follows from how many consecutive cycles
    // lock_sync has been high before the current cycle (m_run).
    logic [SS-1:0] m_hist = '0;
    int            m_run  = 0;
    int            m_lost = 0;
    logic          m_lock_sync;
    logic          m_loss;

    assign m_lock_sync = m_hist[SS-1];
    assign m_loss      = !m_lock_sync && (m_run >= LOCK + 1);

    always @(posedge clock_in or posedge reset) begin
        if (reset) begin
            m_hist <= '0;
            m_run  <= 0;
            m_lost <= 0;
        end else begin
            m_hist <= {m_hist[SS-2:0], pll_locked};
            m_run  <= m_lock_sync ? m_run + 1 : 0;
            if (lost_clear)
                m_lost <= m_loss ? 1 : 0;
            else if (m_loss && m_lost < LMAX)
                m_lost <= m_lost + 1;
        end
    end

    function automatic int exp_rst(input int len);
        int v;
        v = 0;
        for (int i = 0; i < N; i++)
            if (len < LOCK + 1 + i * GAP) v = v | (1 << i);
        return v;
    endfunction

    function automatic int exp_ready(input int len);
        return (len >= REL_L) ? 1 : 0;
    endfunction

    function automatic int exp_tick(input int len);
        return ((len > REL_L) && (((len - REL_L) % TDIV) == 0)) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock_in) begin
        chk("model_rst_out",    int'(rst_out),    exp_rst(m_run));
        chk("model_ready",      int'(ready),      exp_ready(m_run));
        chk("model_tick",       int'(tick),       exp_tick(m_run));
        chk("model_lost_count", int'(lost_count), m_lost);
    end

    task automatic go(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic chk_out(input string tag, input int r, input int rd, input int tk, input int lc);
        chk({tag, "_rst_out"},    int'(rst_out),    r);
        chk({tag, "_ready"},      int'(ready),      rd);
        chk({tag, "_tick"},       int'(tick),       tk);
        chk({tag, "_lost_count"}, int'(lost_count), lc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // 1: reset, then no lock for 50 cycles
        go(3);
        chk_out("reset", 7, 0, 0, 0);
        @(negedge clock_in) reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            go(1);
            chk_out("nolock", 7, 0, 0, 0);
        end

        // 3: one-cycle glitch at COUNT cnt=5 restarts qualification
        @(negedge clock_in) pll_locked = 1'b1;
        go(2);                                     // cycle t
        go(4);                                     // cycle t+4
        @(negedge clock_in) pll_locked = 1'b0;
        @(negedge clock_in) pll_locked = 1'b1;     // mid t+5
        go(4);
        chk_out("glitch_t9", 7, 0, 0, 0);
        go(6);
        chk_out("glitch_t15", 7, 0, 0, 0);
        go(1);
        chk_out("glitch_t16", 6, 0, 0, 0);
        go(8);
        chk_out("glitch_run", 0, 1, 0, 0);

        @(negedge clock_in) begin reset = 1'b1; pll_locked = 1'b0; end
        go(2);
        @(negedge clock_in) reset = 1'b0;
        go(3);
        chk_out("rereset", 7, 0, 0, 0);

        // 2: clean lock and release timing
        @(negedge clock_in) pll_locked = 1'b1;
        go(2);                                     // cycle t
        go(8);
        chk_out("seq_t8", 7, 0, 0, 0);
        go(1);
        chk_out("seq_t9", 6, 0, 0, 0);
        go(3);
        chk_out("seq_t12", 6, 0, 0, 0);
        go(1);
        chk_out("seq_t13", 4, 0, 0, 0);
        go(3);
        chk_out("seq_t16", 4, 0, 0, 0);
        go(1);
        chk_out("seq_t17", 0, 1, 0, 0);
        go(4);
        chk_out("seq_t21", 0, 1, 0, 0);
        go(1);
        chk_out("seq_t22", 0, 1, 1, 0);
        go(1);
        chk_out("seq_t23", 0, 1, 0, 0);
        go(4);
        chk_out("seq_t27", 0, 1, 1, 0);

        // 4: loss in RUN
        @(negedge clock_in) pll_locked = 1'b0;
        go(2);
        chk_out("loss_before", 0, 1, 0, 0);
        go(1);
        chk_out("loss_after", 7, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            go(1);
            chk("loss_tick_stopped", int'(tick), 0);
        end
        @(negedge clock_in) pll_locked = 1'b1;
        go(2 + 9);
        chk_out("relock_t9", 6, 0, 0, 1);
        go(8);
        chk_out("relock_t17", 0, 1, 0, 1);

        // 5: saturation, then clear coinciding with a loss
        for (int k = 2; k <= 4; k++) begin
            @(negedge clock_in) pll_locked = 1'b0;
            go(3);
            chk("sat_lost_count", int'(lost_count), (k > LMAX) ? LMAX : k);
            @(negedge clock_in) pll_locked = 1'b1;
            go(2 + REL_L);
            chk("sat_ready", int'(ready), 1);
        end
        @(negedge clock_in) pll_locked = 1'b0;
        go(2);
        @(negedge clock_in) lost_clear = 1'b1;
        go(1);
        chk_out("clear_with_loss", 7, 0, 0, 1);
        @(negedge clock_in) lost_clear = 1'b0;
        go(1);
        chk("clear_with_loss_hold", int'(lost_count), 1);
        @(negedge clock_in) lost_clear = 1'b1;
        @(negedge clock_in) lost_clear = 1'b0;
        #1;
        chk("plain_clear", int'(lost_count), 0);

        // 6: asynchronous reset mid-RELEASE
        @(negedge clock_in) pll_locked = 1'b1;
        go(2 + 10);
        chk_out("release_t10", 6, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_out("async_reset", 7, 0, 0, 0);
        @(negedge clock_in) begin reset = 1'b0; pll_locked = 1'b0; end
        go(5);
        chk_out("post_reset", 7, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
